// File: rtl/apb_master_if.sv
// Command/response handshake and APB bus of the rotate-block register initiator.
// The master modport belongs to apb_master; the slave modport belongs to whatever drives it.
interface apb_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        pwrite;
   logic        psel;
   logic        penable;
   logic [31:0] prdata;
   logic        pready;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata, pready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwdata, pwrite, psel, penable
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata, pready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwdata, pwrite, psel, penable
   );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: one command in, one SETUP/ACCESS transfer out,
// one response back, with an optional PREADY timeout.
module apb_master #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic         I_APBM_PCLK,
   input  logic         I_APBM_PRESET,
   apb_master_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam logic        TIMEOUT_EN   = 1'(TIMEOUT != 0);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

   state_e      state_q;
   logic [15:0] wait_cnt_q;
   logic [15:0] wait_cnt_d;
   logic        timeout_hit_s;
   logic [31:0] paddr_q;
   logic [31:0] pwdata_q;
   logic        pwrite_q;
   logic        psel_q;
   logic        penable_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;

   // Wait counter next value and timeout detection on the last permitted ACCESS cycle.
   always_comb begin
      wait_cnt_d    = wait_cnt_q + 16'd1;
      timeout_hit_s = 1'b0;
      if (TIMEOUT_EN && (wait_cnt_q == TIMEOUT_LAST)) begin
         timeout_hit_s = 1'b1;
      end else begin
         timeout_hit_s = 1'b0;
      end
   end

   // Transfer FSM; every bus and response output is a flop written only here.
   always_ff @(posedge I_APBM_PCLK or posedge I_APBM_PRESET) begin
      if (I_APBM_PRESET) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= 16'd0;
         paddr_q     <= 32'd0;
         pwdata_q    <= 32'd0;
         pwrite_q    <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  paddr_q  <= bus.req_addr;
                  pwdata_q <= bus.req_wdata;
                  pwrite_q <= bus.req_write;
                  psel_q   <= 1'b1;
                  state_q  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_q  <= 1'b1;
               wait_cnt_q <= 16'd0;
               state_q    <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (bus.pready) begin
                  rsp_rdata_q <= pwrite_q ? 32'd0 : bus.prdata;
                  rsp_err_q   <= 1'b0;
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end else if (timeout_hit_s) begin
                  rsp_rdata_q <= 32'd0;
                  rsp_err_q   <= 1'b1;
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_d;
               end
            end
            ST_RESP: begin
               // Address/data/direction deliberately keep their last values here.
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  wait_cnt_q  <= 16'd0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               psel_q      <= 1'b0;
               penable_q   <= 1'b0;
               rsp_valid_q <= 1'b0;
               wait_cnt_q  <= 16'd0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a memory-backed APB slave with programmable
// PREADY latency, plus a second instance with the timeout disabled.
module tb_apb_master;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   apb_master_if bus ();
   apb_master_if bus0 ();

   apb_master #(.TIMEOUT(16)) dut (
      .I_APBM_PCLK   (clk),
      .I_APBM_PRESET (rst),
      .bus           (bus.master)
   );

   apb_master #(.TIMEOUT(0)) dut0 (
      .I_APBM_PCLK   (clk),
      .I_APBM_PRESET (rst),
      .bus           (bus0.master)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [32:0] exp_q[$];
   int          slave_lat = 1;
   int          acc_cnt = 0;
   logic [31:0] mem [logic [31:0]];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // APB slave: PREADY after slave_lat ACCESS cycles; PREADY=1 outside ACCESS must be ignored.
   initial begin
      bus.pready = 1'b0;
      bus.prdata = 32'h0;
      forever begin
         @(negedge clk);
         if (bus.psel && bus.penable) begin
            bus.pready = (acc_cnt >= slave_lat);
            if (bus.pready && bus.pwrite) mem[bus.paddr] = bus.pwdata;
            bus.prdata = mem.exists(bus.paddr) ? mem[bus.paddr] : 32'hDEAD_BEEF;
            acc_cnt++;
         end else begin
            acc_cnt    = 0;
            bus.pready = 1'b1;
            bus.prdata = 32'h5A5A_5A5A;
         end
      end
   end

   task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d, output bit ok);
      int t = 0;
      ok = 1'b0;
      while (!bus.req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus.req_ready) begin
         check("req_ready_wait", 0, 1);
         return;
      end
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(negedge clk);
      bus.req_valid = 1'b0;
      ok = 1'b1;
   endtask

   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [32:0] expv, input int hold, input int exp_psel, input int exp_pen);
      bit          ok;
      int          np = 0;
      int          ne = 0;
      int          t = 0;
      logic [31:0] rd;
      logic [32:0] e;
      send(wr, a, d, ok);
      if (!ok) return;
      exp_q.push_back(expv);
      while (!bus.rsp_valid && t < 200) begin
         if (bus.psel) begin
            np++;
            check("paddr_stable", bus.paddr, a);
            check("pwrite", bus.pwrite, wr);
            if (wr) check("pwdata", bus.pwdata, d);
         end
         if (bus.penable) ne++;
         @(negedge clk);
         t++;
      end
      if (!bus.rsp_valid) begin
         check("rsp_wait", 0, 1);
         exp_q.delete();
         return;
      end
      check("psel_cycles", np, exp_psel);
      check("penable_cycles", ne, exp_pen);
      check("psel_in_resp", {bus.psel, bus.penable}, 2'b00);
      rd = bus.rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         bus.req_valid = (i == 1);
         bus.req_addr  = 32'h44;
         check("hold_rsp_valid", bus.rsp_valid, 1);
         check("hold_rdata", bus.rsp_rdata, rd);
         check("hold_req_ready", bus.req_ready, 0);
         check("hold_psel", bus.psel, 0);
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      e = exp_q.pop_front();
      check("rsp_err", bus.rsp_err, e[32]);
      check("rsp_rdata", bus.rsp_rdata, e[31:0]);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("rsp_valid_drop", bus.rsp_valid, 0);
      check("req_ready_idle", bus.req_ready, 1);
      check("no_extra_xfer", bus.psel, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit          ok;
      int          t;
      int          ne;
      bit          seen;
      int          r1;
      int          s2;
      bit          acc;
      logic [32:0] e;

      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
      bus.rsp_ready = 1'b0;
      bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
      bus0.rsp_ready = 1'b0; bus0.pready = 1'b0; bus0.prdata = 32'h0;
      mem[32'h18] = 32'h0000_0002;
      mem[32'h38] = 32'hCAFE_0038;

      repeat (3) @(posedge clk);
      #1;
      check("rst_psel_penable_pwrite", {bus.psel, bus.penable, bus.pwrite}, 3'b000);
      check("rst_rsp_valid_err", {bus.rsp_valid, bus.rsp_err}, 2'b00);
      check("rst_paddr", bus.paddr, 0);
      check("rst_pwdata", bus.pwdata, 0);
      check("rst_rdata", bus.rsp_rdata, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 1);

      // Basic write, readback, and the register read of 0x18.
      xfer(1'b1, 32'h08, 32'h0000_0140, {1'b0, 32'h0}, 0, 3, 2);
      xfer(1'b0, 32'h08, 32'h0, {1'b0, 32'h0000_0140}, 0, 3, 2);
      xfer(1'b0, 32'h18, 32'h0, {1'b0, 32'h0000_0002}, 0, 3, 2);

      // PREADY on exactly the 16th ACCESS cycle still succeeds; never ready times out.
      slave_lat = 15;
      xfer(1'b0, 32'h18, 32'h0, {1'b0, 32'h0000_0002}, 0, 17, 16);
      slave_lat = 1000;
      xfer(1'b0, 32'h18, 32'h0, {1'b1, 32'h0}, 0, 17, 16);
      slave_lat = 3;
      xfer(1'b1, 32'h10, 32'h1234_5678, {1'b0, 32'h0}, 0, 5, 4);
      slave_lat = 1;

      // Response held off for 5 cycles while a stray command is offered.
      xfer(1'b0, 32'h10, 32'h0, {1'b0, 32'h1234_5678}, 5, 3, 2);

      // Reset during ACCESS discards the transfer.
      send(1'b1, 32'h30, 32'h55, ok);
      t = 0;
      while (!bus.penable && t < 10) begin
         @(negedge clk);
         t++;
      end
      check("reached_access", bus.penable, 1);
      rst = 1'b1;
      #1;
      check("midrst_psel_penable_rspv", {bus.psel, bus.penable, bus.rsp_valid}, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.rsp_valid || bus.psel) seen = 1'b1;
      end
      check("midrst_no_rsp", seen, 0);
      check("midrst_req_ready", bus.req_ready, 1);
      xfer(1'b1, 32'h30, 32'h0000_0077, {1'b0, 32'h0}, 0, 3, 2);
      xfer(1'b0, 32'h30, 32'h0, {1'b0, 32'h0000_0077}, 0, 3, 2);

      // TIMEOUT=0 instance holds ACCESS indefinitely.
      bus0.req_valid = 1'b1;
      bus0.req_write = 1'b0;
      bus0.req_addr  = 32'h40;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      ne = 0;
      seen = 1'b0;
      for (int i = 0; i < 120; i++) begin
         if (bus0.psel && bus0.penable) ne++;
         if (bus0.rsp_valid) seen = 1'b1;
         @(negedge clk);
      end
      check("notimeout_access_cycles", ne, 119);
      check("notimeout_no_rsp", seen, 0);
      check("notimeout_still_access", {bus0.psel, bus0.penable}, 2'b11);

      // Back-to-back write then read with RSP_READY tied high.
      bus.rsp_ready = 1'b1;
      send(1'b1, 32'h20, 32'h0000_0001, ok);
      if (ok) exp_q.push_back({1'b0, 32'h0});
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h38;
      bus.req_wdata = 32'h0;
      r1 = -100;
      s2 = -1;
      for (int i = 0; i < 40; i++) begin
         if (bus.rsp_valid) begin
            if (r1 < 0) r1 = i;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("b2b_rsp_err", bus.rsp_err, e[32]);
               check("b2b_rsp_rdata", bus.rsp_rdata, e[31:0]);
            end else begin
               check("b2b_unexpected_rsp", 1, 0);
            end
         end
         if (bus.psel && !bus.penable && bus.paddr == 32'h38 && s2 < 0) s2 = i;
         acc = bus.req_valid && bus.req_ready;
         if (acc) exp_q.push_back({1'b0, 32'hCAFE_0038});
         @(negedge clk);
         if (acc) bus.req_valid = 1'b0;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      check("b2b_setup_gap", s2 - r1, 2);
      check("b2b_all_responses", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
